// File: rtl/page_walk_arbiter.sv
// Page-walk arbiter: one request slot per requester, round-robin grant onto a
// single shared page-table walker, result broadcast back by requester ID, with
// flush handling that drops queued work and suppresses in-flight results.
module page_walk_arbiter #(
    parameter int unsigned NUM_RQ = 3,
    parameter int unsigned ID_W   = $clog2(NUM_RQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     IN_flush,

    input  logic [NUM_RQ-1:0]        IN_rqValid,
    input  logic [NUM_RQ-1:0][31:0]  IN_rqAddr,
    input  logic [NUM_RQ-1:0][21:0]  IN_rqRootPPN,
    output logic [NUM_RQ-1:0]        OUT_rqBusy,

    output logic                     OUT_walkValid,
    output logic [31:0]              OUT_walkAddr,
    output logic [21:0]              OUT_walkRootPPN,
    output logic [ID_W-1:0]          OUT_walkRqID,
    input  logic                     IN_walkReady,

    input  logic                     IN_walkDone,
    input  logic [21:0]              IN_walkPPN,
    input  logic [2:0]               IN_walkRWX,
    input  logic                     IN_walkUser,
    input  logic                     IN_walkIsSuper,
    input  logic                     IN_walkPageFault,

    output logic                     OUT_resValid,
    output logic [ID_W-1:0]          OUT_resRqID,
    output logic [21:0]              OUT_resPPN,
    output logic [2:0]               OUT_resRWX,
    output logic                     OUT_resUser,
    output logic                     OUT_resIsSuper,
    output logic                     OUT_resPageFault
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned PPN_W  = 22;
    localparam int unsigned RWX_W  = 3;
    localparam int unsigned SUM_W  = ID_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    // Request slots
    logic [NUM_RQ-1:0]             r_slotValid;
    logic [NUM_RQ-1:0][ADDR_W-1:0] r_slotAddr;
    logic [NUM_RQ-1:0][PPN_W-1:0]  r_slotRootPPN;

    // Round-robin pointer and walker-side registers
    logic [ID_W-1:0]   r_rrPtr;
    logic              r_walkValid;
    logic [ADDR_W-1:0] r_walkAddr;
    logic [PPN_W-1:0]  r_walkRootPPN;
    logic [ID_W-1:0]   r_walkRqID;

    // Result registers
    logic              r_resValid;
    logic [ID_W-1:0]   r_resRqID;
    logic [PPN_W-1:0]  r_resPPN;
    logic [RWX_W-1:0]  r_resRWX;
    logic              r_resUser;
    logic              r_resIsSuper;
    logic              r_resPageFault;

    // Arbitration and control wires
    logic              w_anyValid;
    logic [ID_W-1:0]   w_winner;
    logic [ID_W-1:0]   w_rrNext;
    logic              w_grant;
    logic              w_resFire;
    logic              w_walkValidNext;

    // Round-robin search: first valid slot at or after r_rrPtr, wrapping
    always_comb begin
        logic [SUM_W-1:0] w_candSum;
        logic [ID_W-1:0]  w_cand;
        w_anyValid = 1'b0;
        w_winner   = '0;
        w_candSum  = '0;
        w_cand     = '0;
        for (int k = 0; k < NUM_RQ; k++) begin
            w_candSum = SUM_W'(r_rrPtr) + SUM_W'(k);
            if (w_candSum >= SUM_W'(NUM_RQ)) begin
                w_candSum = w_candSum - SUM_W'(NUM_RQ);
            end
            w_cand = w_candSum[ID_W-1:0];
            if (!w_anyValid && r_slotValid[w_cand]) begin
                w_anyValid = 1'b1;
                w_winner   = w_cand;
            end
        end
        w_rrNext = (w_winner == ID_W'(NUM_RQ - 1)) ? '0 : w_winner + ID_W'(1);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // FSM next-state; a flush that races a handshake decides whether the walker still owes a done
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_anyValid && !IN_flush) w_stateNext = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (IN_flush)          w_stateNext = IN_walkReady ? ST_DRAIN : ST_IDLE;
                else if (IN_walkReady) w_stateNext = ST_WAIT;
            end
            ST_WAIT: begin
                if (IN_flush)         w_stateNext = IN_walkDone ? ST_IDLE : ST_DRAIN;
                else if (IN_walkDone) w_stateNext = ST_IDLE;
            end
            ST_DRAIN: begin
                if (IN_walkDone) w_stateNext = ST_IDLE;
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // FSM output decode: grant, result delivery and next walk-valid
    always_comb begin
        w_grant         = 1'b0;
        w_resFire       = 1'b0;
        w_walkValidNext = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_grant         = w_anyValid && !IN_flush;
                w_walkValidNext = w_anyValid && !IN_flush;
            end
            ST_ISSUE: begin
                w_walkValidNext = !IN_flush && !IN_walkReady;
            end
            ST_WAIT: begin
                w_resFire = IN_walkDone && !IN_flush;
            end
            default: begin
                w_grant = 1'b0;
            end
        endcase
    end

    // Slot capture, per-slot clear on result delivery, global clear on flush
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slotValid   <= '0;
            r_slotAddr    <= '0;
            r_slotRootPPN <= '0;
        end else begin
            for (int i = 0; i < NUM_RQ; i++) begin
                if (IN_flush) begin
                    r_slotValid[i] <= 1'b0;
                end else if (w_resFire && (r_walkRqID == ID_W'(i))) begin
                    r_slotValid[i] <= 1'b0;
                end else if (!r_slotValid[i] && IN_rqValid[i]) begin
                    r_slotValid[i]   <= 1'b1;
                    r_slotAddr[i]    <= IN_rqAddr[i];
                    r_slotRootPPN[i] <= IN_rqRootPPN[i];
                end
            end
        end
    end

    // Walker request registers and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rrPtr       <= '0;
            r_walkValid   <= 1'b0;
            r_walkAddr    <= '0;
            r_walkRootPPN <= '0;
            r_walkRqID    <= '0;
        end else begin
            r_walkValid <= w_walkValidNext;
            if (w_grant) begin
                r_rrPtr       <= w_rrNext;
                r_walkAddr    <= r_slotAddr[w_winner];
                r_walkRootPPN <= r_slotRootPPN[w_winner];
                r_walkRqID    <= w_winner;
            end
        end
    end

    // Result registers; valid is a single-cycle pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resValid     <= 1'b0;
            r_resRqID      <= '0;
            r_resPPN       <= '0;
            r_resRWX       <= '0;
            r_resUser      <= 1'b0;
            r_resIsSuper   <= 1'b0;
            r_resPageFault <= 1'b0;
        end else begin
            r_resValid <= w_resFire;
            if (w_resFire) begin
                r_resRqID      <= r_walkRqID;
                r_resPPN       <= IN_walkPPN;
                r_resRWX       <= IN_walkRWX;
                r_resUser      <= IN_walkUser;
                r_resIsSuper   <= IN_walkIsSuper;
                r_resPageFault <= IN_walkPageFault;
            end
        end
    end

    assign OUT_rqBusy       = r_slotValid;
    assign OUT_walkValid    = r_walkValid;
    assign OUT_walkAddr     = r_walkAddr;
    assign OUT_walkRootPPN  = r_walkRootPPN;
    assign OUT_walkRqID     = r_walkRqID;
    assign OUT_resValid     = r_resValid;
    assign OUT_resRqID      = r_resRqID;
    assign OUT_resPPN       = r_resPPN;
    assign OUT_resRWX       = r_resRWX;
    assign OUT_resUser      = r_resUser;
    assign OUT_resIsSuper   = r_resIsSuper;
    assign OUT_resPageFault = r_resPageFault;

endmodule
